// File: rtl/data_mem_access.sv
// Load/store unit: carries one memory instruction at a time onto a single-port
// data memory bus (request/grant, then read-valid for loads), stalls the core
// until the access finishes, and aborts accesses the memory never answers.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a memory instruction; latches bus fields on req_valid
// REQ    | mem_req asserted, waiting for mem_gnt
// WAIT   | load granted, waiting for mem_rvalid
// DONE   | one-cycle completion (done, optional err); core advances here
module data_mem_access #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] mem_data,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  // At least one bit so TIMEOUT=0 (watchdog disabled) still elaborates.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               expire;
  logic               abort;
  logic               err_q;

  assign expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  // Next-state decode; a grant or read-valid in the expiry cycle wins over the abort.
  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      S_IDLE: if (req_valid) state_nx = S_REQ;
      S_REQ: begin
        if (mem_gnt) begin
          state_nx = mem_we ? S_DONE : S_WAIT;
        end else if (expire) begin
          state_nx = S_DONE;
          abort    = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_nx = S_DONE;
        end else if (expire) begin
          state_nx = S_DONE;
          abort    = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Watchdog: zero on REQ entry, counts REQ/WAIT cycles, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
    end else if ((state == S_REQ || state == S_WAIT) && cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Abort flag shown alongside done in the DONE cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= abort;
  end

  // Bus fields latched only in IDLE, so they stay stable from REQ through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == S_IDLE && req_valid) begin
      mem_we    <= req_write;
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
    end
  end

  // Load result; an aborted load returns all-ones, stores leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= '0;
    end else if (state == S_WAIT && mem_rvalid) begin
      mem_data <= mem_rdata;
    end else if (abort && !mem_we) begin
      mem_data <= '1;
    end
  end

  assign mem_req = (state == S_REQ);
  assign done    = (state == S_DONE);
  assign err     = done && err_q;
  // Gated by rst so a held req_valid cannot stall the core while in reset.
  assign stall   = !rst && ((state == S_IDLE && req_valid) ||
                            state == S_REQ || state == S_WAIT);

endmodule

// File: tb/tb_data_mem_access.sv
// Directed, table-driven bench for data_mem_access (TIMEOUT = 8).
module tb_data_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        stall, done, err, mem_req, mem_we;
  logic [15:0] mem_data, mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_access #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .mem_data(mem_data), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv, wr;
    logic [15:0] addr, wd;
    logic        gnt, rvl;
    logic [15:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [15:0] e_addr, e_wdata;
    logic        e_done, e_err;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void p(logic rv, logic wr, logic [15:0] addr, logic [15:0] wd,
                            logic gnt, logic rvl, logic [15:0] rdata,
                            logic st, logic rq, logic we, logic [15:0] ma,
                            logic [15:0] mw, logic dn, logic er, logic [15:0] md);
    vec_t v;
    v.rv = rv; v.wr = wr; v.addr = addr; v.wd = wd;
    v.gnt = gnt; v.rvl = rvl; v.rdata = rdata;
    v.e_stall = st; v.e_req = rq; v.e_we = we; v.e_addr = ma;
    v.e_wdata = mw; v.e_done = dn; v.e_err = er; v.e_data = md;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs just after the edge, compare outputs mid-cycle.
  task automatic apply(input vec_t v, input string name, input int idx);
    logic [54:0] got, exp;
    @(posedge clk);
    #1;
    req_valid = v.rv; req_write = v.wr; req_addr = v.addr; req_wdata = v.wd;
    mem_gnt = v.gnt; mem_rvalid = v.rvl; mem_rdata = v.rdata;
    #4;
    got = {stall, mem_req, mem_we, mem_addr, mem_wdata, done, err, mem_data};
    exp = {v.e_stall, v.e_req, v.e_we, v.e_addr, v.e_wdata, v.e_done, v.e_err, v.e_data};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got st=%b rq=%b we=%b a=%h wd=%h dn=%b er=%b d=%h exp st=%b rq=%b we=%b a=%h wd=%h dn=%b er=%b d=%h",
               name, idx, stall, mem_req, mem_we, mem_addr, mem_wdata, done, err, mem_data,
               v.e_stall, v.e_req, v.e_we, v.e_addr, v.e_wdata, v.e_done, v.e_err, v.e_data);
    end
  endtask

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0055; req_wdata = 16'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;

    // Load, best case: 3 stall cycles, done in c3.
    p(1,0,16'h0010,0, 0,0,0,          1,0,0,16'h0010-16'h0010,0,0,0,16'h0000);
    p(1,0,16'h0010,0, 1,0,0,          1,1,0,16'h0010,0,0,0,16'h0000);
    p(1,0,16'h0010,0, 0,1,16'hBEEF,   1,0,0,16'h0010,0,0,0,16'h0000);
    p(1,0,16'h0010,0, 0,0,0,          0,0,0,16'h0010,0,1,0,16'hBEEF);
    p(0,0,16'h0000,0, 0,0,0,          0,0,0,16'h0010,0,0,0,16'hBEEF);
    // Delayed store: grant withheld 4 cycles, 5 mem_req cycles.
    p(1,1,16'h00FF,16'h1234, 0,0,0,   1,0,0,16'h0010,16'h0000,0,0,16'hBEEF);
    for (int i = 0; i < 4; i++)
      p(1,1,16'h00FF,16'h1234, 0,0,0, 1,1,1,16'h00FF,16'h1234,0,0,16'hBEEF);
    p(1,1,16'h00FF,16'h1234, 1,0,0,   1,1,1,16'h00FF,16'h1234,0,0,16'hBEEF);
    p(1,1,16'h00FF,16'h1234, 0,0,0,   0,0,1,16'h00FF,16'h1234,1,0,16'hBEEF);
    p(0,0,16'h0000,0, 0,0,0,          0,0,1,16'h00FF,16'h1234,0,0,16'hBEEF);
    // Watchdog abort on a granted load: REQ cnt0, WAIT cnt1..8, abort at cnt8.
    p(1,0,16'h0020,0, 0,0,0,          1,0,1,16'h00FF,16'h1234,0,0,16'hBEEF);
    p(1,0,16'h0020,0, 1,0,0,          1,1,0,16'h0020,16'h0000,0,0,16'hBEEF);
    for (int i = 0; i < 8; i++)
      p(1,0,16'h0020,0, 0,0,0,        1,0,0,16'h0020,16'h0000,0,0,16'hBEEF);
    p(1,0,16'h0020,0, 0,0,0,          0,0,0,16'h0020,16'h0000,1,1,16'hFFFF);
    p(0,0,16'h0000,0, 0,1,16'hAAAA,   0,0,0,16'h0020,16'h0000,0,0,16'hFFFF);
    p(0,0,16'h0000,0, 0,0,0,          0,0,0,16'h0020,16'h0000,0,0,16'hFFFF);
    // Store never granted: 9 REQ cycles, abort, mem_data untouched.
    p(1,1,16'h0040,16'h5A5A, 0,0,0,   1,0,0,16'h0020,16'h0000,0,0,16'hFFFF);
    for (int i = 0; i < 9; i++)
      p(1,1,16'h0040,16'h5A5A, 0,0,0, 1,1,1,16'h0040,16'h5A5A,0,0,16'hFFFF);
    p(1,1,16'h0040,16'h5A5A, 0,0,0,   0,0,1,16'h0040,16'h5A5A,1,1,16'hFFFF);
    p(0,0,16'h0000,0, 0,0,0,          0,0,1,16'h0040,16'h5A5A,0,0,16'hFFFF);
    // Completion in the expiry cycle; rvalid in REQ is ignored.
    p(1,0,16'h0030,0, 0,0,0,          1,0,1,16'h0040,16'h5A5A,0,0,16'hFFFF);
    p(1,0,16'h0030,0, 0,1,16'h9999,   1,1,0,16'h0030,16'h0000,0,0,16'hFFFF);
    p(1,0,16'h0030,0, 1,0,0,          1,1,0,16'h0030,16'h0000,0,0,16'hFFFF);
    for (int i = 0; i < 6; i++)
      p(1,0,16'h0030,0, 0,0,0,        1,0,0,16'h0030,16'h0000,0,0,16'hFFFF);
    p(1,0,16'h0030,0, 0,1,16'h1357,   1,0,0,16'h0030,16'h0000,0,0,16'hFFFF);
    p(1,0,16'h0030,0, 0,0,0,          0,0,0,16'h0030,16'h0000,1,0,16'h1357);
    // Back-to-back loads, no reissue.
    p(1,0,16'h0100,0, 0,0,0,          1,0,0,16'h0030,16'h0000,0,0,16'h1357);
    p(1,0,16'h0100,0, 1,0,0,          1,1,0,16'h0100,16'h0000,0,0,16'h1357);
    p(1,0,16'h0100,0, 0,1,16'h1111,   1,0,0,16'h0100,16'h0000,0,0,16'h1357);
    p(1,0,16'h0100,0, 0,0,0,          0,0,0,16'h0100,16'h0000,1,0,16'h1111);
    p(1,0,16'h0102,0, 0,0,0,          1,0,0,16'h0100,16'h0000,0,0,16'h1111);
    p(1,0,16'h0102,0, 1,0,0,          1,1,0,16'h0102,16'h0000,0,0,16'h1111);
    p(1,0,16'h0102,0, 0,1,16'h2222,   1,0,0,16'h0102,16'h0000,0,0,16'h1111);
    p(1,0,16'h0102,0, 0,0,0,          0,0,0,16'h0102,16'h0000,1,0,16'h2222);
    p(0,0,16'h0000,0, 0,0,0,          0,0,0,16'h0102,16'h0000,0,0,16'h2222);

    // Reset state, with req_valid held high during reset.
    #12;
    check1("rst_outs", {10'b0, stall, mem_req, done, err, mem_we, 1'b0}, 16'h0000);
    check1("rst_addr", mem_addr, 16'h0000);
    check1("rst_data", mem_data, 16'h0000);
    req_valid = 1'b0;
    #2 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

    // Reset while a load sits in WAIT.
    p(1,0,16'h0200,0, 0,0,0,          1,0,0,16'h0102,16'h0000,0,0,16'h2222);
    p(1,0,16'h0200,0, 1,0,0,          1,1,0,16'h0200,16'h0000,0,0,16'h2222);
    p(1,0,16'h0200,0, 0,0,0,          1,0,0,16'h0200,16'h0000,0,0,16'h2222);
    for (int i = vecs.size() - 3; i < vecs.size(); i++) apply(vecs[i], "pre_rst", i);
    #2 rst = 1'b1;
    #1;
    check1("mid_rst_ctl", {12'b0, mem_req, stall, done, err}, 16'h0000);
    check1("mid_rst_data", mem_data, 16'h0000);
    check1("mid_rst_addr", mem_addr, 16'h0000);
    #5 req_valid = 1'b0;
    #3 rst = 1'b0;

    // A new load after reset completes normally.
    vecs.delete();
    p(1,0,16'h0300,0, 0,0,0,          1,0,0,16'h0000,16'h0000,0,0,16'h0000);
    p(1,0,16'h0300,0, 0,0,0,          1,1,0,16'h0300,16'h0000,0,0,16'h0000);
    p(1,0,16'h0300,0, 1,0,0,          1,1,0,16'h0300,16'h0000,0,0,16'h0000);
    p(1,0,16'h0300,0, 0,0,0,          1,0,0,16'h0300,16'h0000,0,0,16'h0000);
    p(1,0,16'h0300,0, 0,1,16'h4444,   1,0,0,16'h0300,16'h0000,0,0,16'h0000);
    p(1,0,16'h0300,0, 0,0,0,          0,0,0,16'h0300,16'h0000,1,0,16'h4444);
    p(0,0,16'h0000,0, 0,0,0,          0,0,0,16'h0300,16'h0000,0,0,16'h4444);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "post_rst", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
